// File: rtl/uart_tx_frame_serializer_pkg.sv
// Shared UART definitions: transmit FSM state encoding, line idle level and
// the parity helper used by both the TX framer and the RX checker.
// No ports (package).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Words narrower than 16 bits are zero-extended by the caller; the extra
    // zeros do not change the XOR reduction.
    function automatic logic parity_calc(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_frame_serializer_if.sv
// Parallel word handshake between the TX FIFO (master) and the framer (slave).
// Signals:
//   tx_data    word to send
//   tx_valid   tx_data valid
//   tx_ready   framer can accept a word
//   parity_odd 1 = odd parity, 0 = even (only with UART_TX_PARITY_EN)
// Optional feature macro: UART_TX_PARITY_EN.
interface uart_tx_frame_serializer_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
`ifdef UART_TX_PARITY_EN
    logic                  parity_odd;

    modport master (output tx_data, output tx_valid, output parity_odd, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input parity_odd, output tx_ready);
`else
    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
`endif
endinterface

// File: rtl/uart_tx_shift_reg.sv
// Load/shift register for the TX framer with selectable bit order.
// Ports:
//   clk     clock
//   rst_i   synchronous active-high reset
//   load_i  load data_i (has priority over shift_i)
//   data_i  parallel word
//   shift_i advance to the next bit
//   bit_o   bit currently at the output end (LSB or MSB per LSB_FIRST)
module uart_tx_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    output logic             bit_o
);
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            if (LSB_FIRST != 0) begin
                sr_d = {1'b0, sr_q[WIDTH-1:1]};
            end else begin
                sr_d = {sr_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit_o = (LSB_FIRST != 0) ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART transmit framer: accepts a word over a valid/ready handshake and sends
// start bit, DATA_WIDTH data bits, optional parity bit and STOP_BITS stop bits,
// advancing one bit per baud_tick strobe.
// Ports:
//   clk        clock
//   RST        synchronous active-high reset
//   baud_tick  one-cycle bit-boundary strobe
//   tx_if      word handshake (slave side): tx_data, tx_valid, tx_ready,
//              parity_odd (only with UART_TX_PARITY_EN)
//   tx_out     registered serial line, idle high
//   busy       frame pending or in progress
//   frame_done one-cycle pulse in the first IDLE cycle after the last stop bit
// Optional feature macro: UART_TX_PARITY_EN (adds the parity bit).
module uart_tx_frame_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned LSB_FIRST  = 1,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          RST,
    input  logic                          baud_tick,
    uart_tx_frame_serializer_if.slave     tx_if,
    output logic                          tx_out,
    output logic                          busy,
    output logic                          frame_done
);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_out_q, tx_out_d;
    logic                 done_q, done_d;
    logic                 load, shift, sr_bit;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    uart_tx_shift_reg #(
        .WIDTH     (DATA_WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk     (clk),
        .rst_i   (RST),
        .load_i  (load),
        .data_i  (tx_if.tx_data),
        .shift_i (shift),
        .bit_o   (sr_bit)
    );

    // tx_out is registered, so each tick drives the bit for the period it
    // opens: the shift register is advanced whenever its current bit is
    // copied to the line, leaving the next bit waiting at the output end.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_out_d   = tx_out_q;
        done_d     = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tx_if.tx_valid) begin
                    load    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    // Parity bit is resolved at acceptance so later input changes cannot leak in.
                    parity_d = parity_calc(16'(tx_if.tx_data), tx_if.parity_odd);
`endif
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (baud_tick) begin
                    tx_out_d = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_out_d = sr_bit;
                    shift    = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (cnt_q == CNT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_out_d = parity_q;
                        state_d  = ST_PARITY;
`else
                        tx_out_d   = UART_IDLE_LEVEL;
                        stop_cnt_d = 1'b0;
                        state_d    = ST_STOP;
`endif
                    end else begin
                        tx_out_d = sr_bit;
                        shift    = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    tx_out_d   = UART_IDLE_LEVEL;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        stop_cnt_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            stop_cnt_q <= 1'b0;
            tx_out_q   <= UART_IDLE_LEVEL;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_out_q   <= tx_out_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_if.tx_ready = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign tx_out         = tx_out_q;
    assign frame_done     = done_q;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Directed bench for uart_tx_frame_serializer: two instances (8N1 LSB-first
// and 5-bit MSB-first with two stop bits) sharing clock, reset and baud_tick.
// Expected line sequences are written per tick as strings, first bit first.
module tb_uart_tx_frame_serializer;

    logic clk = 1'b0;
    logic RST;
    logic baud_tick;

    always #5 clk = ~clk;

    uart_tx_frame_serializer_if #(.DATA_WIDTH(8)) if_a ();
    uart_tx_frame_serializer_if #(.DATA_WIDTH(5)) if_b ();

    logic a_out, a_busy, a_done;
    logic b_out, b_busy, b_done;

    uart_tx_frame_serializer #(
        .DATA_WIDTH (8),
        .STOP_BITS  (1),
        .LSB_FIRST  (1)
    ) u_a (
        .clk        (clk),
        .RST        (RST),
        .baud_tick  (baud_tick),
        .tx_if      (if_a),
        .tx_out     (a_out),
        .busy       (a_busy),
        .frame_done (a_done)
    );

    uart_tx_frame_serializer #(
        .DATA_WIDTH (5),
        .STOP_BITS  (2),
        .LSB_FIRST  (0)
    ) u_b (
        .clk        (clk),
        .RST        (RST),
        .baud_tick  (baud_tick),
        .tx_if      (if_b),
        .tx_out     (b_out),
        .busy       (b_busy),
        .frame_done (b_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        baud_tick = 1'b1;
        step();
        baud_tick = 1'b0;
    endtask

    // Steps one tick per expected line bit, then one final tick that ends the
    // last stop bit and must produce the frame_done pulse.
    task automatic run_frame(input bit sel_b, input string tag, input string seq);
        logic exp_bit;
        for (int i = 0; i < seq.len(); i++) begin
            exp_bit = (seq[i] == 8'h31);
            tick();
            check($sformatf("%s_line%0d", tag, i), sel_b ? b_out : a_out, exp_bit);
            check($sformatf("%s_ready%0d", tag, i), sel_b ? if_b.tx_ready : if_a.tx_ready, 1'b0);
            check($sformatf("%s_done%0d", tag, i), sel_b ? b_done : a_done, 1'b0);
            step();
            step();
        end
        tick();
        check({tag, "_done_pulse"}, sel_b ? b_done : a_done, 1'b1);
        check({tag, "_end_busy"}, sel_b ? b_busy : a_busy, 1'b0);
        check({tag, "_end_ready"}, sel_b ? if_b.tx_ready : if_a.tx_ready, 1'b1);
        check({tag, "_end_line"}, sel_b ? b_out : a_out, 1'b1);
        step();
        check({tag, "_done_clear"}, sel_b ? b_done : a_done, 1'b0);
    endtask

    initial begin
        RST           = 1'b1;
        baud_tick     = 1'b0;
        if_a.tx_valid = 1'b0;
        if_a.tx_data  = '0;
        if_b.tx_valid = 1'b0;
        if_b.tx_data  = '0;
`ifdef UART_TX_PARITY_EN
        if_a.parity_odd = 1'b0;
        if_b.parity_odd = 1'b0;
`endif
        step();
        step();
        RST = 1'b0;

        check("rst_a_line", a_out, 1'b1);
        check("rst_a_ready", if_a.tx_ready, 1'b1);
        check("rst_a_busy", a_busy, 1'b0);
        check("rst_a_done", a_done, 1'b0);
        check("rst_b_line", b_out, 1'b1);
        check("rst_b_busy", b_busy, 1'b0);

        // Ticks while idle with no word offered.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_a_line", a_out, 1'b1);
            check("idle_a_busy", a_busy, 1'b0);
            check("idle_b_busy", b_busy, 1'b0);
            step();
        end

        // 8N1, LSB first, 0xA5; input changed after acceptance must not matter.
        if_a.tx_valid = 1'b1;
        if_a.tx_data  = 8'hA5;
        step();
        check("a5_acc_ready", if_a.tx_ready, 1'b0);
        check("a5_acc_busy", a_busy, 1'b1);
        check("a5_acc_line", a_out, 1'b1);
        if_a.tx_valid = 1'b0;
        if_a.tx_data  = 8'h3C;
`ifdef UART_TX_PARITY_EN
        if_a.parity_odd = 1'b1;
        run_frame(1'b0, "a5_even", "01010010101");

        if_a.tx_valid   = 1'b1;
        if_a.tx_data    = 8'hA5;
        if_a.parity_odd = 1'b1;
        step();
        if_a.tx_valid   = 1'b0;
        if_a.parity_odd = 1'b0;
        run_frame(1'b0, "a5_odd", "01010010111");
`else
        run_frame(1'b0, "a5", "0101001011");
`endif

        // 5 data bits, MSB first, two stop bits, 0x13.
        if_b.tx_valid = 1'b1;
        if_b.tx_data  = 5'h13;
        step();
        check("b13_acc_ready", if_b.tx_ready, 1'b0);
        if_b.tx_valid = 1'b0;
        if_b.tx_data  = 5'h0C;
`ifdef UART_TX_PARITY_EN
        run_frame(1'b1, "b13", "010011111");
`else
        run_frame(1'b1, "b13", "01001111");
`endif

        // Back-to-back with tx_valid held: 0x00 then 0xFF.
        if_a.tx_valid = 1'b1;
        if_a.tx_data  = 8'h00;
        step();
        if_a.tx_data  = 8'hFF;
`ifdef UART_TX_PARITY_EN
        run_frame(1'b0, "b2b_00", "00000000001");
`else
        run_frame(1'b0, "b2b_00", "0000000001");
`endif
        // The next word was taken in the frame_done cycle.
        check("b2b_second_acc_ready", if_a.tx_ready, 1'b0);
        check("b2b_second_acc_busy", a_busy, 1'b1);
        if_a.tx_valid = 1'b0;
        if_a.tx_data  = 8'h00;
`ifdef UART_TX_PARITY_EN
        run_frame(1'b0, "b2b_ff", "01111111101");
`else
        run_frame(1'b0, "b2b_ff", "0111111111");
`endif

        // Reset during data bit 3 of 0xA5.
        if_a.tx_valid = 1'b1;
        if_a.tx_data  = 8'hA5;
        step();
        if_a.tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            step();
        end
        check("abort_pre_line_bit3", a_out, 1'b0);
        check("abort_pre_busy", a_busy, 1'b1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("abort_line", a_out, 1'b1);
        check("abort_busy", a_busy, 1'b0);
        check("abort_ready", if_a.tx_ready, 1'b1);
        check("abort_done", a_done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_after_done", a_done, 1'b0);
            check("abort_after_line", a_out, 1'b1);
        end

        // Reset wins over a handshake in the same cycle.
        RST           = 1'b1;
        if_a.tx_valid = 1'b1;
        if_a.tx_data  = 8'h5A;
        step();
        RST           = 1'b0;
        if_a.tx_valid = 1'b0;
        check("rst_prio_ready", if_a.tx_ready, 1'b1);
        check("rst_prio_busy", a_busy, 1'b0);
        step();
        check("rst_prio_busy_after", a_busy, 1'b0);
        tick();
        check("rst_prio_line", a_out, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
